// File: rtl/remote_cmd_pkg.sv
// Shared types and constants for the remote command initiator.
package remote_cmd_pkg;
  typedef enum logic [1:0] {IDLE, TX_HI, TX_LO, WAIT_ACK} state_t;
  localparam logic [7:0] ACK_BYTE   = 8'hA5;
  localparam int         FRAME_BITS = 10;
endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit, BAUD_DIV clocks each.
// A load on the byte_done cycle chains the next frame with no idle gap.
module uart_byte_tx
  import remote_cmd_pkg::*;
#(
  parameter int BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       TX,
  output logic       byte_done
);
  localparam int BW = $clog2(BAUD_DIV);

  logic [BW-1:0] r_baud;
  logic [3:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_active;
  logic          w_bit_end;

  assign w_bit_end = r_active && (r_baud == BW'(BAUD_DIV - 1));
  assign byte_done = w_bit_end && (r_bit == 4'(FRAME_BITS - 1));
  assign TX        = r_tx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
      r_active <= 1'b0;
    end else if (load) begin
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= byte_in;
      r_tx     <= 1'b0;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (w_bit_end) begin
        r_baud <= '0;
        if (byte_done) begin
          r_bit    <= '0;
          r_tx     <= 1'b1;
          r_active <= 1'b0;
        end else begin
          // Ones shifted in behind the data become the stop bit.
          r_bit   <= r_bit + 4'd1;
          r_tx    <= r_shift[0];
          r_shift <= {1'b1, r_shift[7:1]};
        end
      end else begin
        r_baud <= r_baud + BW'(1);
      end
    end
  end
endmodule

// File: rtl/remote_cmd_tx.sv
// Sends a 16-bit command as two back-to-back 8N1 bytes (high first), then waits for a response byte.
// Define ACK_TIMEOUT_EN to add the TMO_CYCLES response timeout and the resp_tmo pulse.
module remote_cmd_tx
  import remote_cmd_pkg::*;
#(
  parameter int BAUD_DIV   = 5208
`ifdef ACK_TIMEOUT_EN
  ,
  parameter int TMO_CYCLES = 1000000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        TX,
  output logic        busy,
  output logic        cmd_sent,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [7:0]  resp,
  output logic        resp_vld,
  output logic        resp_ok
`ifdef ACK_TIMEOUT_EN
  ,
  output logic        resp_tmo
`endif
);
  state_t     r_state, w_next;
  logic [7:0] r_cmd_lo;
  logic       r_cmd_sent, r_resp_vld, r_clr, r_resp_ok;
  logic [7:0] r_resp;
  logic       w_load, w_byte_done, w_take_resp;
  logic [7:0] w_byte;
  logic       w_tmo;

  uart_byte_tx #(.BAUD_DIV(BAUD_DIV)) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .byte_in  (w_byte),
    .TX       (TX),
    .byte_done(w_byte_done)
  );

`ifdef ACK_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYCLES + 1);
  logic [TW-1:0] r_tmo_cnt;
  logic          r_resp_tmo;

  assign w_tmo    = (r_state == WAIT_ACK) && (r_tmo_cnt == TW'(TMO_CYCLES - 1));
  assign resp_tmo = r_resp_tmo;

  always_ff @(posedge clk) begin
    if (rst || r_state != WAIT_ACK) r_tmo_cnt <= '0;
    else                            r_tmo_cnt <= r_tmo_cnt + TW'(1);
    // A response on the expiry cycle takes precedence over the timeout.
    if (rst) r_resp_tmo <= 1'b0;
    else     r_resp_tmo <= w_tmo && !rx_rdy;
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (snd_cmd)     w_next = TX_HI;
      TX_HI:    if (w_byte_done) w_next = TX_LO;
      TX_LO:    if (w_byte_done) w_next = WAIT_ACK;
      WAIT_ACK: if (rx_rdy || w_tmo) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != IDLE);
    w_take_resp = (r_state == WAIT_ACK) && rx_rdy;
    w_load      = ((r_state == IDLE) && snd_cmd) || ((r_state == TX_HI) && w_byte_done);
    // High byte goes straight from the port on the accept cycle; low byte from the latch.
    w_byte      = (r_state == IDLE) ? cmd[15:8] : r_cmd_lo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_lo   <= '0;
      r_cmd_sent <= 1'b0;
      r_resp_vld <= 1'b0;
      r_clr      <= 1'b0;
      r_resp     <= 8'h00;
      r_resp_ok  <= 1'b0;
    end else begin
      if ((r_state == IDLE) && snd_cmd) r_cmd_lo <= cmd[7:0];
      r_cmd_sent <= (r_state == TX_LO) && w_byte_done;
      r_resp_vld <= w_take_resp;
      r_clr      <= w_take_resp;
      if (w_take_resp) begin
        r_resp    <= rx_data;
        r_resp_ok <= (rx_data == ACK_BYTE);
      end
    end
  end

  assign cmd_sent   = r_cmd_sent;
  assign resp_vld   = r_resp_vld;
  assign clr_rx_rdy = r_clr;
  assign resp       = r_resp;
  assign resp_ok    = r_resp_ok;
endmodule

// File: tb/tb_remote_cmd_tx.sv
// Directed bench for remote_cmd_tx at BAUD_DIV=4 (timeout checks when ACK_TIMEOUT_EN is defined).
module tb_remote_cmd_tx;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        TX, busy, cmd_sent, clr_rx_rdy, resp_vld, resp_ok;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic [7:0]  resp;
`ifdef ACK_TIMEOUT_EN
  logic        resp_tmo;
`endif

  int n_vec = 0;
  int n_err = 0;
  // 2C then 5A, each framed start/LSB-first data/stop.
  logic [0:19] exp_bits = 20'b0_00110100_1_0_01011010_1;

  always #5 clk = ~clk;

  remote_cmd_tx #(
    .BAUD_DIV  (4)
`ifdef ACK_TIMEOUT_EN
    ,
    .TMO_CYCLES(50)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd),
    .snd_cmd   (snd_cmd),
    .TX        (TX),
    .busy      (busy),
    .cmd_sent  (cmd_sent),
    .rx_rdy    (rx_rdy),
    .rx_data   (rx_data),
    .clr_rx_rdy(clr_rx_rdy),
    .resp      (resp),
    .resp_vld  (resp_vld),
    .resp_ok   (resp_ok)
`ifdef ACK_TIMEOUT_EN
    ,
    .resp_tmo  (resp_tmo)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sends 16'h2C5A; optionally disturbs it, or resets at cycle rst_at of the frame.
  task automatic send(input bit inject, input int rst_at);
    cmd = 16'h2C5A; snd_cmd = 1'b1;
    tick;
    snd_cmd = 1'b0;
    chk("busy_accept", 16'(busy), 16'd1);
    for (int i = 0; i < 80; i++) begin
      if (inject && i == 10) begin snd_cmd = 1'b1; cmd = 16'hFFFF; end
      if (inject && i == 12) snd_cmd = 1'b0;
      if (inject && i == 50) begin rx_rdy = 1'b1; rx_data = 8'h00; end
      if (inject && i == 58) rx_rdy = 1'b0;
      if (i == rst_at) begin
        rst = 1'b1;
        tick;
        chk("tx_after_rst", 16'(TX), 16'd1);
        chk("busy_after_rst", 16'(busy), 16'd0);
        chk("resp_after_rst", 16'(resp), 16'h00);
        rst = 1'b0;
        return;
      end
      chk($sformatf("tx_bit%0d", i), 16'(TX), 16'(exp_bits[i / 4]));
      if (inject) chk("no_clr_outside_wait", 16'(clr_rx_rdy), 16'd0);
      if (i == 79) chk("cmd_sent_early", 16'(cmd_sent), 16'd0);
      tick;
    end
    chk("cmd_sent", 16'(cmd_sent), 16'd1);
    chk("tx_idle_wait", 16'(TX), 16'd1);
    chk("busy_wait", 16'(busy), 16'd1);
  endtask

  task automatic respond(input logic [7:0] d, input logic ok);
    rx_rdy = 1'b1; rx_data = d;
    tick;
    rx_rdy = 1'b0;
    chk("resp", 16'(resp), 16'(d));
    chk("resp_ok", 16'(resp_ok), 16'(ok));
    chk("resp_vld", 16'(resp_vld), 16'd1);
    chk("clr_rx_rdy", 16'(clr_rx_rdy), 16'd1);
    chk("busy_done", 16'(busy), 16'd0);
    tick;
    chk("resp_vld_pulse", 16'(resp_vld), 16'd0);
    chk("clr_pulse", 16'(clr_rx_rdy), 16'd0);
    chk("resp_hold", 16'(resp), 16'(d));
  endtask

  initial begin
    rst = 1'b1; cmd = '0; snd_cmd = 1'b0; rx_rdy = 1'b0; rx_data = '0;
    repeat (3) tick;
    chk("rst_tx", 16'(TX), 16'd1);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_cmd_sent", 16'(cmd_sent), 16'd0);
    chk("rst_clr", 16'(clr_rx_rdy), 16'd0);
    chk("rst_resp", 16'(resp), 16'h00);
    chk("rst_resp_vld", 16'(resp_vld), 16'd0);
    chk("rst_resp_ok", 16'(resp_ok), 16'd0);
    rst = 1'b0;
    tick;

    send(1'b0, -1);
    respond(8'hA5, 1'b1);
    send(1'b0, -1);
    respond(8'h3C, 1'b0);

    send(1'b1, -1);
    chk("resp_not_captured", 16'(resp), 16'h3C);
    respond(8'h5A, 1'b0);

    send(1'b0, 60);
    tick;
    send(1'b0, -1);
    respond(8'hA5, 1'b1);

    send(1'b0, -1);
`ifdef ACK_TIMEOUT_EN
    repeat (49) tick;
    chk("tmo_early", 16'(resp_tmo), 16'd0);
    tick;
    chk("tmo_pulse", 16'(resp_tmo), 16'd1);
    chk("tmo_busy", 16'(busy), 16'd0);
    chk("tmo_resp_kept", 16'(resp), 16'hA5);
    tick;
    chk("tmo_pulse_end", 16'(resp_tmo), 16'd0);
`else
    repeat (60) tick;
    chk("no_tmo_busy", 16'(busy), 16'd1);
    chk("no_tmo_resp", 16'(resp), 16'hA5);
    respond(8'h3C, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
